// File: rtl/pri_codec_pkg.sv
// pri_codec_pkg
//   Shared types and helpers for the priority encode/decode path.
//   - IDX_W_DEF / N_DEF : default index width and decoded vector width
//   - entry_t           : one buffered encoder result {none, idx}
//   - onehot_of()       : index -> one-hot lane vector
//   - thermo_of()       : index -> all lanes at or below the index
//                         (only with PRI_DECODER_THERMO_MASK_EN defined)
package pri_codec_pkg;

  localparam int IDX_W_DEF = 3;
  localparam int N_DEF     = 2 ** IDX_W_DEF;

  typedef struct packed {
    logic                 none;
    logic [IDX_W_DEF-1:0] idx;
  } entry_t;

  function automatic logic [N_DEF-1:0] onehot_of(input logic [IDX_W_DEF-1:0] idx);
    logic [N_DEF-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

`ifdef PRI_DECODER_THERMO_MASK_EN
  function automatic logic [N_DEF-1:0] thermo_of(input logic [IDX_W_DEF-1:0] idx);
    logic [N_DEF-1:0] vec;
    for (int k = 0; k < N_DEF; k++) begin
      vec[k] = (IDX_W_DEF'(k) <= idx);
    end
    return vec;
  endfunction
`endif

endpackage

// File: rtl/pri_codec_fifo.sv
// pri_codec_fifo
//   Generic DEPTH-entry synchronous FIFO (DEPTH must be a power of two).
//   Ports:
//     clk, rst        - clock, synchronous active-high reset
//     push, push_data - write request and data (ignored when full)
//     pop             - read request (ignored when empty)
//     head            - oldest entry (undefined while empty)
//     full, empty     - occupancy flags
//     count           - number of stored entries, 0..DEPTH
module pri_codec_fifo
  import pri_codec_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = entry_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T               mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Callers are expected to respect full/empty; flag it if they do not.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full))  else $error("pri_codec_fifo: push while full");
      assert (!(pop && empty))  else $error("pri_codec_fifo: pop while empty");
      assert (count <= CNT_W'(DEPTH)) else $error("pri_codec_fifo: count overflow");
    end
  end

endmodule

// File: rtl/pri_decoder_3to8_buf.sv
// pri_decoder_3to8_buf
//   Buffered inverse of the 8-to-3 priority encoder: stores {none, idx}
//   results in a small FIFO and regenerates the one-hot grant vector for
//   the head entry.
//   Ports:
//     clk, rst                       - clock, synchronous active-high reset
//     in_valid, in_ready             - upstream handshake
//     in_idx, in_none                - encoded index and all-zero flag
//     out_valid, out_ready           - downstream handshake
//     out_onehot                     - decoded one-hot vector of head entry
//     out_mask                       - lanes at or below head index
//                                      (only with PRI_DECODER_THERMO_MASK_EN)
//   Optional feature macro: PRI_DECODER_THERMO_MASK_EN
module pri_decoder_3to8_buf
  import pri_codec_pkg::*;
#(
  parameter int  IDX_W = 3,
  parameter int  DEPTH = 2,
  localparam int N     = 2 ** IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_none,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_onehot
`ifdef PRI_DECODER_THERMO_MASK_EN
  ,
  output logic [N-1:0]     out_mask
`endif
);

  typedef struct packed {
    logic             none;
    logic [IDX_W-1:0] idx;
  } slot_t;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  slot_t            wr_slot;
  slot_t            head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [N-1:0]     onehot_dec;

  assign wr_slot = '{none: in_none, idx: in_idx};

  // Both handshakes are forced off while rst is high so nothing is
  // accepted or delivered in a flushing cycle.
  assign in_ready  = !full && !rst;
  assign out_valid = !empty && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  pri_codec_fifo #(
    .DEPTH (DEPTH),
    .T     (slot_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_slot),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  generate
    if (IDX_W == IDX_W_DEF) begin : g_pkg_dec
      assign onehot_dec = onehot_of(head.idx);
    end else begin : g_loop_dec
      always_comb begin
        onehot_dec = '0;
        for (int k = 0; k < N; k++) begin
          onehot_dec[k] = (head.idx == IDX_W'(k));
        end
      end
    end
  endgenerate

  // A "none" entry still presents out_valid but decodes to all zeros.
  assign out_onehot = (out_valid && !head.none) ? onehot_dec : '0;

`ifdef PRI_DECODER_THERMO_MASK_EN
  logic [N-1:0] thermo_dec;

  generate
    if (IDX_W == IDX_W_DEF) begin : g_pkg_thermo
      assign thermo_dec = thermo_of(head.idx);
    end else begin : g_loop_thermo
      always_comb begin
        thermo_dec = '0;
        for (int k = 0; k < N; k++) begin
          thermo_dec[k] = (IDX_W'(k) <= head.idx);
        end
      end
    end
  endgenerate

  assign out_mask = (out_valid && !head.none) ? thermo_dec : '0;
`endif

  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_pri_decoder_3to8_buf.sv
// tb_pri_decoder_3to8_buf
//   Table-driven bench for pri_decoder_3to8_buf with hand-written reset
//   sequences. Inputs are driven on the falling edge; outputs are checked
//   shortly after, ahead of the next rising edge.
module tb_pri_decoder_3to8_buf;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic       in_none;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
`ifdef PRI_DECODER_THERMO_MASK_EN
  logic [7:0] out_mask;
`endif

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       in_valid;
    logic [2:0] in_idx;
    logic       in_none;
    logic       out_ready;
    logic       exp_valid;
    logic [7:0] exp_onehot;
    logic       exp_ready;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t vecs[$];

  pri_decoder_3to8_buf #(
    .IDX_W (3),
    .DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_none    (in_none),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot)
`ifdef PRI_DECODER_THERMO_MASK_EN
    ,
    .out_mask   (out_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic iv, input logic [2:0] idx, input logic none,
                        input logic ordy, input logic ev, input logic [7:0] eoh,
                        input logic erdy, input logic [7:0] emask);
    vec_t v;
    v.in_valid   = iv;
    v.in_idx     = idx;
    v.in_none    = none;
    v.out_ready  = ordy;
    v.exp_valid  = ev;
    v.exp_onehot = eoh;
    v.exp_ready  = erdy;
    v.exp_mask   = emask;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input int row);
    @(negedge clk);
    in_valid  = v.in_valid;
    in_idx    = v.in_idx;
    in_none   = v.in_none;
    out_ready = v.out_ready;
    #1;
    checkOutput($sformatf("row%0d out_valid", row), 32'(out_valid), 32'(v.exp_valid));
    checkOutput($sformatf("row%0d out_onehot", row), 32'(out_onehot), 32'(v.exp_onehot));
    checkOutput($sformatf("row%0d in_ready", row), 32'(in_ready), 32'(v.exp_ready));
`ifdef PRI_DECODER_THERMO_MASK_EN
    checkOutput($sformatf("row%0d out_mask", row), 32'(out_mask), 32'(v.exp_mask));
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_idx    = 3'd0;
    in_none   = 1'b0;
    out_ready = 1'b0;

    // Power-on reset: handshakes held off during reset, ready right after.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_onehot", 32'(out_onehot), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);

    // Stream idx 0..7 with a free consumer; each shows up one cycle later.
    for (int i = 0; i <= 8; i++) begin
      addVec((i < 8), 3'(i), 1'b0, 1'b1,
             (i > 0),
             (i > 0) ? 8'(16'(1) << (i - 1)) : 8'h00,
             1'b1,
             (i > 0) ? 8'((16'(1) << i) - 16'd1) : 8'h00);
    end
    addVec(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);

    // "none" entry round-trips as valid with an all-zero vector.
    addVec(1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    addVec(1'b0, 3'd0,   1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
    addVec(1'b0, 3'd0,   1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);

    // Back-pressure: 4 and 6 accepted, 2 refused, then drained in order.
    addVec(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    addVec(1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 8'h1F);
    addVec(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h1F);
    addVec(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 8'h1F);
    addVec(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 8'h7F);
    addVec(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);

    // Simultaneous push/pop at count=1 keeps count at 1 and FIFO order.
    addVec(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    addVec(1'b1, 3'd7, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 8'h0F);
    addVec(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 8'hFF);
    addVec(1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 8'hFF);
    addVec(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 8'hFF);
    addVec(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 8'hFF);
    addVec(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 8'h03);
    addVec(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);

    foreach (vecs[r]) begin
      applyStimulus(vecs[r], r);
    end

    // Mid-operation reset with two buffered entries flushes them.
    @(negedge clk);
    in_valid  = 1'b1;
    in_idx    = 3'd2;
    in_none   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    in_idx = 3'd5;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("full in_ready", 32'(in_ready), 32'd0);
    checkOutput("full head", 32'(out_onehot), 32'h04);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("mid-reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid-reset out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("flush out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush out_onehot", 32'(out_onehot), 32'd0);
    checkOutput("flush in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("flush stays empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
